// File: rtl/map_dispatcher.sv
// Map dispatcher: queues idle mapper requests round-robin into an ID FIFO
// and hands each source point to the oldest queued mapper with a grant pulse.
//
// Point handshake: a point transfers ("fire") in any cycle where
// point_ready_out and point_valid_in are both 1. point_ready_out is purely
// combinational and never depends on point_valid_in. The source may hold or
// change point_data_in freely while point_ready_out is 0.
module map_dispatcher #(
  parameter int NUM_MAPPERS = 4,
  parameter int IDX_BITS    = 2,
  parameter int DIMENSION   = 2,
  parameter int PRECISION   = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [COUNT_WIDTH-1:0]         num_points,
  input  logic [DIMENSION*PRECISION-1:0] point_data_in,
  input  logic                           point_valid_in,
  output logic                           point_ready_out,
  input  logic [NUM_MAPPERS-1:0]         request,
  output logic [NUM_MAPPERS-1:0]         queued,
  output logic [NUM_MAPPERS-1:0]         grant,
  output logic [DIMENSION*PRECISION-1:0] value_data_out,
  output logic                           busy,
  output logic                           job_done,
  output logic [COUNT_WIDTH-1:0]         dispatched_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] target;

  // Queued mapper IDs in arrival order; one slot per mapper is enough
  // because a mapper with pending set is never queued again.
  logic [IDX_BITS-1:0]    fifo_mem [NUM_MAPPERS];
  logic [IDX_BITS-1:0]    head;
  logic [IDX_BITS-1:0]    tail;
  logic [IDX_BITS:0]      fifo_count;
  logic [IDX_BITS-1:0]    fifo_head;

  logic [NUM_MAPPERS-1:0] pending;
  logic [IDX_BITS-1:0]    rr_ptr;
  logic [IDX_BITS-1:0]    cand;
  logic [IDX_BITS-1:0]    sel_idx;
  logic                   sel_found;
  logic [NUM_MAPPERS-1:0] push_mask;
  logic [NUM_MAPPERS-1:0] pop_mask;
  logic                   fire;
  logic                   last_fire;

  // Round-robin pick of one requesting, not-yet-pending mapper, starting at rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_MAPPERS; k++) begin
      cand = IDX_BITS'((int'(rr_ptr) + k) % NUM_MAPPERS);
      if (!sel_found && request[cand] && !pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Handshake and one-hot push/pop masks.
  always_comb begin
    fifo_head       = fifo_mem[head];
    point_ready_out = (state == DISPATCH) && (fifo_count != '0) &&
                      (dispatched_count < target);
    fire            = point_ready_out && point_valid_in;
    last_fire       = fire && ((dispatched_count + COUNT_WIDTH'(1)) == target);
    push_mask       = sel_found ? (NUM_MAPPERS'(1) << sel_idx) : '0;
    pop_mask        = fire ? (NUM_MAPPERS'(1) << fifo_head) : '0;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = (num_points != '0) ? DISPATCH : DONE;
      DISPATCH: if (last_fire) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    busy     = (state == DISPATCH);
    job_done = (state == DONE);
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clock) begin
    if (sel_found) fifo_mem[tail] <= sel_idx;
  end

  // FIFO pointers, pending mask and round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
      pending    <= '0;
      rr_ptr     <= '0;
    end else begin
      pending <= (pending | push_mask) & ~pop_mask;
      if (sel_found) begin
        tail   <= (tail == IDX_BITS'(NUM_MAPPERS - 1)) ? '0 : tail + 1'b1;
        rr_ptr <= (sel_idx == IDX_BITS'(NUM_MAPPERS - 1)) ? '0 : sel_idx + 1'b1;
      end
      if (fire) head <= (head == IDX_BITS'(NUM_MAPPERS - 1)) ? '0 : head + 1'b1;
      case ({sel_found, fire})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Job counters, pulse outputs and the registered point bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      target           <= '0;
      dispatched_count <= '0;
      queued           <= '0;
      grant            <= '0;
      value_data_out   <= '0;
    end else begin
      queued <= push_mask;
      grant  <= pop_mask;
      if (state == IDLE && start) begin
        target           <= num_points;
        dispatched_count <= '0;
      end else if (fire) begin
        dispatched_count <= dispatched_count + COUNT_WIDTH'(1);
      end
      if (fire) value_data_out <= point_data_in;
    end
  end

endmodule

// File: doc/map_dispatcher.md
MAP_DISPATCHER -- requirements
Module: map_dispatcher

Interface
REQ-001 Parameter NUM_MAPPERS, default 4, number of mapper units served.
REQ-002 Parameter IDX_BITS, default 2, log2(NUM_MAPPERS).
REQ-003 Parameter DIMENSION, default 2, coordinates per data point.
REQ-004 Parameter PRECISION, default 16, bits per coordinate.
REQ-005 Parameter COUNT_WIDTH, default 16, width of point counters.
REQ-006 Port list (name, direction, width, meaning); the block SHALL provide exactly these ports:
- clock, in, 1: one clock; all state changes on its rising edge.
- reset, in, 1: asynchronous, active-high.
- start, in, 1: job start pulse.
- num_points, in, COUNT_WIDTH: points in the job, sampled on accepted start.
- point_data_in, in, DIMENSION*PRECISION: next point from the source.
- point_valid_in, in, 1: point_data_in is valid.
- point_ready_out, out, 1: dispatcher consumes the point this cycle.
- request, in, NUM_MAPPERS: per-mapper idle request.
- queued, out, NUM_MAPPERS: per-mapper one-cycle "request queued" pulse.
- grant, out, NUM_MAPPERS: per-mapper one-cycle start pulse.
- value_data_out, out, DIMENSION*PRECISION: shared point bus to all mappers.
- busy, out, 1: job in progress.
- job_done, out, 1: one-cycle pulse when the last point is granted.
- dispatched_count, out, COUNT_WIDTH: points granted in the current job.

Function
REQ-007 The FSM SHALL have states IDLE, DISPATCH and DONE.
REQ-008 In IDLE, start=1 SHALL latch num_points and clear dispatched_count; next state SHALL be DISPATCH if num_points>0, otherwise DONE.
REQ-009 start SHALL be ignored in DISPATCH and DONE.
REQ-010 DONE SHALL last exactly one cycle, assert job_done=1 and return to IDLE.
REQ-011 busy SHALL be 1 exactly when the state is DISPATCH.
REQ-012 The block SHALL keep a pending[NUM_MAPPERS] mask and an index FIFO of depth NUM_MAPPERS holding queued mapper IDs in arrival order.
REQ-013 Each cycle, in any state, the block SHALL select at most one mapper i with request[i]=1 and pending[i]=0.
- Selection SHALL be round-robin, starting from the index after the last queued mapper.
- Index 0 SHALL be checked first after reset.
REQ-014 For the selected mapper, at the next edge the block SHALL:
- push i into the FIFO;
- set pending[i];
- drive queued[i]=1 for exactly one cycle.
REQ-015 A request held high while pending[i]=1 SHALL NOT be queued again.
REQ-016 The FIFO SHALL never overflow: each mapper holds at most one entry.
REQ-017 point_ready_out SHALL be combinational: 1 iff state=DISPATCH, FIFO non-empty, and dispatched_count<latched num_points.
REQ-018 A fire SHALL occur when point_ready_out=1 and point_valid_in=1.
REQ-019 On a fire, at the next edge the block SHALL:
- pop FIFO head h;
- clear pending[h];
- register point_data_in into value_data_out;
- drive grant[h]=1 for exactly one cycle;
- increment dispatched_count.
REQ-020 value_data_out SHALL be valid in the same cycle as grant and SHALL hold until the next fire.
REQ-021 At most one grant bit SHALL be high in any cycle; queued and grant SHALL each be one-hot or zero.
REQ-022 A push and a pop in the same cycle SHALL both take effect. A mapper whose queued pulse and FIFO entry become visible at the same edge SHALL NOT be granted before that edge.
REQ-023 The fire that makes dispatched_count equal num_points SHALL move the FSM to DONE, so job_done coincides with the final grant.
REQ-024 Pending entries SHALL persist across jobs and be served first in the next job.
REQ-025 No fire SHALL occur outside DISPATCH. point_valid_in is don't-care when point_ready_out=0.

Reset
REQ-026 reset=1 SHALL immediately and asynchronously drive:
- state to IDLE;
- FIFO empty, pending=0, round-robin pointer=0;
- queued=0, grant=0, value_data_out=0, point_ready_out=0, busy=0, job_done=0, dispatched_count=0.
REQ-027 Reset mid-job SHALL abort the job with no further grant pulses. After release, operation SHALL resume only on a new start.

Verification
REQ-028 The bench SHALL cover these scenarios:
- Reset only: all outputs 0 after asynchronous assertion and with no clock edge.
- Basic job: mapper 2 requests, start with num_points=1, point valid (data 0x00050003). Required: queued[2] one cycle, then grant[2] one cycle with value_data_out=0x00050003 and job_done in the same cycle, dispatched_count=1.
- Simultaneous requests: all 4 request in one cycle. Required: queued pulses on 0,1,2,3 in consecutive cycles; with num_points=4 and continuous valid points, grants in order 0,1,2,3; job_done with the 4th grant.
- Back-pressure: point_valid_in=0 with FIFO non-empty. Required: point_ready_out=1, no grant, count unchanged. Raising valid causes a grant on the next edge.
- Held request: mapper 1 holds request 5 cycles while pending. Required: exactly one queued[1] pulse and one FIFO entry.
- Mid-job reset: reset asserted after 2 of num_points=4 grants. Required: outputs immediately 0, busy=0, no grants until a new start; num_points=0 start gives job_done one cycle later with no grant.
